// File: rtl/button_event_arbiter_pkg.sv
// button_event_arbiter_pkg
// Shared types and constants for the button event arbiter.
//   evt_t              : one queued event {channel id, auto-repeat flag}
//   EVT_ID_MAX_W       : storage width of the id field. It bounds WIDTH to 256
//                        channels; narrower ids are zero-extended into it.
//   evt_id_w()         : id width for a given channel count (minimum 1)
//   DEFAULT_FIFO_DEPTH : default event FIFO depth
package button_event_arbiter_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int EVT_ID_MAX_W       = 8;

  function automatic int evt_id_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  typedef struct packed {
    logic [EVT_ID_MAX_W-1:0] id;
    logic                    rpt;
  } evt_t;

endpackage

// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if
// Valid/ready event port carrying the FIFO head.
//   evt_valid  : head event present (master -> slave)
//   evt_ready  : consumer accepts head (slave -> master)
//   evt_id     : channel index of head event
//   evt_repeat : head event is an auto-repeat
// Modports: master (event producer), slave (event consumer).
interface button_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;

  modport master (output evt_valid, output evt_id, output evt_repeat, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_repeat, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The search starts one past the last granted index and
// the pointer advances only when a grant is actually issued.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-channel requests
//   en          : grant enable (downstream has room)
//   grant       : one-hot grant (zero when nothing granted)
//   grant_idx   : index of granted channel
//   grant_valid : a grant was issued this cycle
module rr_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = evt_id_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             en,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] last_reg;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // Offsets 1..WIDTH visit every channel once, ending on last_reg itself.
    for (int k = 1; k <= WIDTH; k++) begin
      cand = IDX_W'((int'(last_reg) + k) % WIDTH);
      if (en && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= '0;
    end else if (grant_valid) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Turns debounced button levels into a serialized stream of press events.
// Rising edges (and, optionally, auto-repeat ticks) set a per-channel pending
// request; a round-robin arbiter moves one request per cycle into a shared
// event FIFO whose head is presented on a valid/ready port.
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_in       : debounced button levels, synchronous to clk
//   evt          : event port (master): evt_valid/evt_ready/evt_id/evt_repeat
//   pending      : per-channel requests waiting for a FIFO slot
//   overflow     : sticky, a request was coalesced into an existing one
//   clr_overflow : synchronous clear of overflow (a same-cycle set wins)
// Optional feature: define BTN_AUTOREPEAT_EN for per-channel hold counters
// that issue repeat events after HOLD_DELAY cycles and then every
// REPEAT_PERIOD cycles. Without it evt_repeat is constant 0.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 12500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        btn_in,
  button_event_arbiter_if.master  evt,
  output logic [WIDTH-1:0]        pending,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int ID_W  = evt_id_w(WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] prev_reg, pending_reg, flag_reg;
  logic [WIDTH-1:0] pending_next, flag_next;
  logic [WIDTH-1:0] rise, tick, req, grant;
  logic             overflow_reg, ovf_set;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_valid;

  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full, empty, pop, push, arb_en;
  evt_t             head, push_evt;

  assign rise = btn_in & ~prev_reg;

`ifdef BTN_AUTOREPEAT_EN
  localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_EN = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hold
      logic [CNT_W-1:0] cnt_reg;
      logic             phase_reg;  // 0: waiting for first repeat, 1: periodic

      assign tick[gi] = btn_in[gi] & prev_reg[gi] &
                        (cnt_reg == (phase_reg ? REP_LIM : HOLD_LIM));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          phase_reg <= 1'b0;
        end else if (!btn_in[gi] || rise[gi]) begin
          cnt_reg   <= '0;
          phase_reg <= 1'b0;
        end else if (tick[gi]) begin
          cnt_reg   <= '0;
          phase_reg <= 1'b1;
        end else begin
          cnt_reg   <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate
`else
  localparam bit REPEAT_EN = 1'b0;
  assign tick = '0;
`endif

  assign req = rise | tick;

  // FIFO status. A pop frees a slot in the same cycle, so a full FIFO can
  // still accept a grant while the consumer is draining.
  assign full   = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign empty  = (count_reg == '0);
  assign pop    = !empty && evt.evt_ready;
  assign arb_en = !full || pop;
  assign push   = grant_valid;

  rr_arbiter #(
    .WIDTH (WIDTH),
    .IDX_W (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (pending_reg),
    .en          (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A new request on a channel that is granted this cycle re-arms the
  // pending bit with the new flag; otherwise it coalesces into the existing
  // request (original flag kept) and flags overflow.
  always_comb begin
    pending_next = pending_reg & ~grant;
    flag_next    = flag_reg;
    ovf_set      = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        if (pending_next[i]) begin
          ovf_set = 1'b1;
        end else begin
          pending_next[i] = 1'b1;
          flag_next[i]    = tick[i];
        end
      end
    end
  end

  always_comb begin
    push_evt     = '0;
    push_evt.id  = EVT_ID_MAX_W'(grant_idx);
    push_evt.rpt = flag_reg[grant_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg     <= '0;
      pending_reg  <= '0;
      flag_reg     <= '0;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      prev_reg     <= btn_in;
      pending_reg  <= pending_next;
      flag_reg     <= flag_next;
      overflow_reg <= ovf_set | (overflow_reg & ~clr_overflow);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Storage has no reset: occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_evt;
  end

  assign head           = mem[rd_ptr_reg];
  assign evt.evt_valid  = !empty;
  assign evt.evt_id     = empty ? '0 : ID_W'(head.id);
  assign evt.evt_repeat = !empty && head.rpt && REPEAT_EN;
  assign pending        = pending_reg;
  assign overflow       = overflow_reg;

endmodule
